// File: rtl/regfile_wb_arbiter_if.sv
// Write-source handshakes and the registered register-file write port seen by regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             pipe_we;
  logic [4:0]       pipe_waddr;
  logic [31:0]      pipe_wdata;
  logic             mc_valid;
  logic             mc_ready;
  logic [4:0]       mc_waddr;
  logic [31:0]      mc_wdata;
  logic             we;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic             stall_req;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, mc_valid, mc_waddr, mc_wdata,
    output mc_ready, we, waddr, wdata, stall_req, fifo_count
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, mc_valid, mc_waddr, mc_wdata,
    input  mc_ready, we, waddr, wdata, stall_req, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register-file write port: pipeline writeback beats buffered multi-cycle results.
// Defining WB_STARVE_GUARD_EN forces the FIFO head after STARVE_MAX denied cycles, stalling the pipe.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave io_wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       r_mem_addr [FIFO_DEPTH];
  logic [31:0]      r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic             w_full;
  logic             w_empty;
  logic             w_mc_ready;
  logic             w_pipe_req;
  logic             w_push;
  logic             w_pop;
  logic             w_force;
  logic             w_nxt_we;
  logic [4:0]       w_nxt_waddr;
  logic [31:0]      w_nxt_wdata;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_mc_ready = rst & ~w_full;
  assign w_pipe_req = io_wb.pipe_we & (io_wb.pipe_waddr != 5'd0);
  // Writes to r0 still complete the handshake but never occupy a slot.
  assign w_push     = io_wb.mc_valid & w_mc_ready & (io_wb.mc_waddr != 5'd0);

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] r_starve;

  assign w_force = (r_starve == SC_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (!w_empty && w_pipe_req) begin
      r_starve <= r_starve + SC_W'(1);
    end
  end
`else
  assign w_force = 1'b0;
  if (STARVE_MAX < 1) begin : g_starve_max_unused
  end
`endif

  always_comb begin
    w_pop       = 1'b0;
    w_nxt_we    = 1'b0;
    w_nxt_waddr = r_waddr;
    w_nxt_wdata = r_wdata;
    if (!w_empty && (w_force || !w_pipe_req)) begin
      w_pop       = 1'b1;
      w_nxt_we    = 1'b1;
      w_nxt_waddr = r_mem_addr[r_rptr];
      w_nxt_wdata = r_mem_data[r_rptr];
    end else if (w_pipe_req) begin
      w_nxt_we    = 1'b1;
      w_nxt_waddr = io_wb.pipe_waddr;
      w_nxt_wdata = io_wb.pipe_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_we    <= w_nxt_we;
      r_waddr <= w_nxt_waddr;
      r_wdata <= w_nxt_wdata;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= io_wb.mc_waddr;
      r_mem_data[r_wptr] <= io_wb.mc_wdata;
    end
  end

  assign io_wb.mc_ready   = w_mc_ready;
  assign io_wb.stall_req  = w_force;
  assign io_wb.we         = r_we;
  assign io_wb.waddr      = r_waddr;
  assign io_wb.wdata      = r_wdata;
  assign io_wb.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random stimulus for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) wb ();
  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_wb (wb)
  );

  int total = 0;
  int bad   = 0;

  logic [36:0] q[$];
  int          m_starve = 0;
  logic        m_we     = 1'b0;
  logic [4:0]  m_waddr  = '0;
  logic [31:0] m_wdata  = '0;
  logic        m_stall  = 1'b0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_stall  = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance, check registered outputs.
  task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic        ready, preq, frc, push;
    logic [36:0] head;
    wb.pipe_we = pv; wb.pipe_waddr = pa; wb.pipe_wdata = pd;
    wb.mc_valid = mv; wb.mc_waddr = ma; wb.mc_wdata = md;
    #1;
    ready = (q.size() < DEPTH);
    preq  = pv && (pa != 5'd0);
    frc   = GUARD && (m_starve == STARVE) && (q.size() > 0);
    push  = mv && ready && (ma != 5'd0);
    obs_stall = wb.stall_req;
    check("mc_ready", wb.mc_ready, ready);
    check("stall_req", wb.stall_req, frc);
    if (q.size() > 0 && (frc || !preq)) begin
      head = q.pop_front();
      m_we = 1'b1; m_waddr = head[36:32]; m_wdata = head[31:0];
      m_starve = 0;
    end else if (preq) begin
      m_we = 1'b1; m_waddr = pa; m_wdata = pd;
      if (q.size() > 0) m_starve++;
    end else begin
      m_we = 1'b0;
    end
    if (push) q.push_back({ma, md});
    m_stall = frc;
    @(posedge clk);
    #1;
    check("we", wb.we, m_we);
    check("waddr", wb.waddr, m_waddr);
    check("wdata", wb.wdata, m_wdata);
    check("fifo_count", wb.fifo_count, q.size());
  endtask

  initial begin
    logic        pv, mv;
    logic [4:0]  pa, ma;
    logic [31:0] pd, md;
    int          stall_iter;

    wb.pipe_we = 1'b0; wb.pipe_waddr = '0; wb.pipe_wdata = '0;
    wb.mc_valid = 1'b0; wb.mc_waddr = '0; wb.mc_wdata = '0;
    #2;
    check("rst_we", wb.we, 1'b0);
    check("rst_waddr", wb.waddr, 5'd0);
    check("rst_wdata", wb.wdata, 32'd0);
    check("rst_count", wb.fifo_count, 3'd0);
    check("rst_mc_ready", wb.mc_ready, 1'b0);
    check("rst_stall", wb.stall_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Pipe-only writes, then a write to r0 that must be ignored.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("pipe_waddr5", wb.waddr, 5'd5);
    check("pipe_wdata", wb.wdata, 32'hDEADBEEF);
    cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    check("pipe_r0_we", wb.we, 1'b0);

    // Fill: five handshakes offered while the pipe owns the port.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'(1 + i), 32'hC000 + i);
    check("fill_count", wb.fifo_count, 3'd4);
    check("fill_ready", wb.mc_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("drain_addr", wb.waddr, 5'(1 + i));
    end

    // Discard: r0 handshake leaves nothing behind.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0BAD0);
    check("discard_count", wb.fifo_count, 3'd0);
    check("discard_we", wb.we, 1'b0);

    // Starvation: r7 queued behind a continuously busy pipe.
    cycle(1'b1, 5'd3, 32'h3333, 1'b1, 5'd7, 32'h7777);
    stall_iter = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0);
      if (obs_stall && stall_iter < 0) stall_iter = i;
    end
    check("starve_iter", stall_iter, GUARD ? 32'd8 : 32'hFFFFFFFF);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    if (!GUARD) check("late_r7", wb.waddr, 5'd7);

    // Random traffic, pipe-heavy first half to provoke the guard.
    pv = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        pv = (i < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
        pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd = $urandom;
      end
      mv = ($urandom_range(0, 1) == 1);
      ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md = $urandom;
      cycle(pv, pa, pd, mv, ma, md);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset mid-burst with three buffered entries.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd9, 32'h9999, 1'b1, 5'(20 + i), 32'hE000 + i);
    check("pre_rst_count", wb.fifo_count, 3'd3);
    wb.mc_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_we", wb.we, 1'b0);
    check("mid_rst_count", wb.fifo_count, 3'd0);
    check("mid_rst_ready", wb.mc_ready, 1'b0);
    @(posedge clk); #1;
    check("held_rst_we", wb.we, 1'b0);
    check("held_rst_count", wb.fifo_count, 3'd0);
    wb.pipe_we = 1'b0; wb.mc_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("post_rst_ready", wb.mc_ready, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd31, 32'hFFFF0000, 1'b1, 5'd4, 32'h4444);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("post_rst_mc", wb.waddr, 5'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
